audio_clkgen: RTL and testbench
===============================

Name: audio_clkgen

Overview:
Parametrised audio clock generator for the codec interface. It derives MCLK, BCLK and a shared LRCLK (ADC/DAC) from the board oscillator and provides a power-on startup delay with a ready flag. It starts and stops cleanly on frame boundaries and offers a runtime sample-rate select. Edge and frame strobes let i2s_tx/i2s_rx and sample generators work synchronously in the system clock domain.

Parameters:
MCLK_DIV, 4, clk cycles per MCLK period; even, >=2 (49.152 MHz -> 12.288 MHz)
BCLK_DIV, 32, clk cycles per BCLK period at sr_sel=0; even, >=4
FRAME_BITS, 32, BCLK periods per LRCLK period; even, >=4
STARTUP_CYCLES, 512, clk cycles after reset release before ready asserts; >=1

Ports:
clk  in  1  system clock (49.152 MHz oscillator)
rst_n  in  1  asynchronous reset, active low
en  in  1  request BCLK/LRCLK generation
sr_sel  in  2  effective BCLK divider = BCLK_DIV << sr_sel (48/24/12/6 kHz at defaults)
mclk  out  1  master clock, 50% duty
bclk  out  1  bit clock
lrclk  out  1  word clock; 0 = left, 1 = right
bclk_rise  out  1  one-cycle pulse, same cycle bclk goes 1
bclk_fall  out  1  one-cycle pulse, same cycle bclk goes 0 (including the frame-start cycle)
frame_start  out  1  one-cycle pulse when bit 0 of a frame begins
bit_index  out  $clog2(FRAME_BITS)  current bit slot within frame
ready  out  1  startup delay elapsed
running  out  1  BCLK/LRCLK active

Behaviour:
- Reset (async, rst_n=0): all outputs 0, all counters 0, sel_q=0, immediately. Applies mid-operation with no partial-frame completion.
- Startup: counter runs from reset release; ready=1 from the clk edge where STARTUP_CYCLES cycles have elapsed, and stays 1 until reset.
- MCLK: free-running from reset release regardless of ready/en. Counter 0..MCLK_DIV-1; mclk=1 while count >= MCLK_DIV/2. Registered output.
- States: IDLE, RUN, DRAIN. running=1 in RUN and DRAIN.
- IDLE: bclk=lrclk=0, no strobes, bit_index=0. If ready && en is sampled high, the next cycle is T0 of RUN.
- T0 (frame start): bcnt=0, bclk=0, lrclk=0, bit_index=0, frame_start=1, bclk_fall=1, sel_q<=sr_sel. Let D = BCLK_DIV << sel_q.
- bcnt counts 0..D-1 and wraps. When bcnt becomes D/2: bclk=1, bclk_rise=1. When bcnt wraps to 0: bclk=0, bclk_fall=1, bit_index increments mod FRAME_BITS.
- lrclk = (bit_index >= FRAME_BITS/2), updated in the same cycle as the bclk fall. It changes only on BCLK falling edges.
- Frame wrap (bit_index FRAME_BITS-1 -> 0): frame_start=1, and sr_sel is resampled into sel_q. sr_sel changes mid-frame have no effect until the next frame, so frames are glitch-free.
- Defaults from T0: bclk rises at T0+16 and falls at T0+32. lrclk rises at T0+512. The next frame_start is at T0+1024, i.e. a 48 kHz frame.
- RUN -> DRAIN when en=0 is sampled. DRAIN finishes the current frame unchanged. If en returns to 1 during DRAIN, go back to RUN with no gap.
- At frame wrap in DRAIN: go to IDLE instead of starting a new frame. No frame_start is issued; bclk, lrclk and bit_index are 0. The final bclk_fall is still asserted.
- en=1 while ready=0: stays IDLE until ready.
- Simultaneous frame wrap and en=0 in RUN: the new frame starts (frame_start=1) and that full frame is drained.
- Strobes are never asserted in IDLE or during reset.

Test Plan:
- Reset release, en=1, defaults -> mclk period 4 clk from reset release. ready=0 for the first 512 cycles, then ready=1. running asserts 1 cycle after ready. frame_start at T0.
- Defaults running -> bclk period 32 clk, 50% duty. lrclk period 1024 clk, rising at T0+512. frame_start every 1024 clk. bit_index steps 0..31 on bclk_fall.
- sr_sel 0 -> 1 mid-frame -> the current frame stays 1024 clk. The next frame has bclk period 64 and frame length 2048. sr_sel=3 gives frame 8192.
- en deasserted at bit_index=5 -> the frame completes through bit_index=31. Then running=0, bclk=lrclk=0, and no further frame_start. Re-assert en -> new T0 the cycle after sampling.
- en toggled 1->0->1 within a single frame -> no gap, frame_start continues every 1024 clk.
- rst_n pulsed low at T0+300 -> all outputs 0 within the same cycle. After release, ready is delayed again by 512 cycles.

Source files
------------

// File: rtl/audio_clkgen.sv
// Audio clock generator: free-running MCLK, framed BCLK/LRCLK with
// start/stop on frame boundaries, runtime sample-rate select, a power-on
// ready delay and single-cycle edge/frame strobes for the clk domain.
module audio_clkgen #(
  parameter int MCLK_DIV       = 4,
  parameter int BCLK_DIV       = 32,
  parameter int FRAME_BITS     = 32,
  parameter int STARTUP_CYCLES = 512
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [1:0]                    sr_sel,
  output logic                          mclk,
  output logic                          bclk,
  output logic                          lrclk,
  output logic                          bclk_rise,
  output logic                          bclk_fall,
  output logic                          frame_start,
  output logic [$clog2(FRAME_BITS)-1:0] bit_index,
  output logic                          ready,
  output logic                          running
);

  localparam int BIW = $clog2(FRAME_BITS);
  localparam int MCW = $clog2(MCLK_DIV);
  localparam int SCW = $clog2(STARTUP_CYCLES + 1);
  // Wide enough to hold the largest divider (sr_sel = 3) itself.
  localparam int BCW = $clog2((BCLK_DIV << 3) + 1);

  localparam logic [MCW-1:0] MCLK_LAST    = MCW'(MCLK_DIV - 1);
  localparam logic [MCW-1:0] MCLK_HALF    = MCW'(MCLK_DIV / 2);
  localparam logic [SCW-1:0] STARTUP_LAST = SCW'(STARTUP_CYCLES - 1);
  localparam logic [BIW-1:0] BIT_LAST     = BIW'(FRAME_BITS - 1);
  localparam logic [BIW-1:0] BIT_HALF     = BIW'(FRAME_BITS / 2);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [MCW-1:0]   mclk_cnt_q, mclk_cnt_d;
  logic             mclk_q, mclk_d;
  logic [SCW-1:0]   start_cnt_q, start_cnt_d;
  logic             ready_q, ready_d;
  logic [BCW-1:0]   bcnt_q, bcnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [BIW-1:0]   bit_q, bit_d;
  logic             bclk_q, bclk_d;
  logic             lrclk_q, lrclk_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             fs_q, fs_d;
  logic             running_q, running_d;

  logic [BCW-1:0]   div_len;
  logic [BCW-1:0]   div_half;
  logic             bit_wrap;
  logic             frame_wrap;
  logic [BIW-1:0]   bit_inc;
  logic             start_frame;

  // MCLK divider and power-on startup delay (both independent of en)
  always_comb begin
    mclk_cnt_d  = (mclk_cnt_q == MCLK_LAST) ? '0 : mclk_cnt_q + 1'b1;
    mclk_d      = (mclk_cnt_d >= MCLK_HALF);
    start_cnt_d = start_cnt_q;
    ready_d     = ready_q;
    if (!ready_q) begin
      start_cnt_d = start_cnt_q + 1'b1;
      ready_d     = (start_cnt_q == STARTUP_LAST);
    end
  end

  // Divider for the frame in progress; sel_q only changes at frame start
  always_comb begin
    div_len    = BCW'(BCLK_DIV) << sel_q;
    div_half   = div_len >> 1;
    bit_wrap   = (bcnt_q == div_len - 1'b1);
    frame_wrap = bit_wrap && (bit_q == BIT_LAST);
    bit_inc    = bit_q + 1'b1;
  end

  // Frame sequencer: IDLE/RUN/DRAIN plus BCLK/LRCLK and strobe generation
  always_comb begin
    state_d     = state_q;
    bcnt_d      = bcnt_q;
    bit_d       = bit_q;
    sel_d       = sel_q;
    bclk_d      = bclk_q;
    lrclk_d     = lrclk_q;
    rise_d      = 1'b0;
    fall_d      = 1'b0;
    fs_d        = 1'b0;
    start_frame = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bcnt_d  = '0;
        bit_d   = '0;
        bclk_d  = 1'b0;
        lrclk_d = 1'b0;
        if (ready_q && en) begin
          state_d     = ST_RUN;
          start_frame = 1'b1;
        end
      end
      ST_RUN, ST_DRAIN: begin
        if (frame_wrap) begin
          // A running frame always rolls over; a draining one only if en came back.
          if (state_q == ST_RUN || en) begin
            state_d     = en ? ST_RUN : ST_DRAIN;
            start_frame = 1'b1;
          end else begin
            state_d = ST_IDLE;
            bcnt_d  = '0;
            bit_d   = '0;
            bclk_d  = 1'b0;
            lrclk_d = 1'b0;
            fall_d  = 1'b1;
          end
        end else begin
          state_d = en ? ST_RUN : ST_DRAIN;
          if (bit_wrap) begin
            bcnt_d  = '0;
            bclk_d  = 1'b0;
            fall_d  = 1'b1;
            bit_d   = bit_inc;
            lrclk_d = (bit_inc >= BIT_HALF);
          end else begin
            bcnt_d = bcnt_q + 1'b1;
            if (bcnt_q + 1'b1 == div_half) begin
              bclk_d = 1'b1;
              rise_d = 1'b1;
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        bcnt_d  = '0;
        bit_d   = '0;
        bclk_d  = 1'b0;
        lrclk_d = 1'b0;
      end
    endcase
    // Frame start: bit 0 begins low with a falling-edge strobe, new rate latched
    if (start_frame) begin
      bcnt_d  = '0;
      bit_d   = '0;
      bclk_d  = 1'b0;
      lrclk_d = 1'b0;
      fs_d    = 1'b1;
      fall_d  = 1'b1;
      sel_d   = sr_sel;
    end
    running_d = (state_d != ST_IDLE);
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mclk_cnt_q  <= '0;
      mclk_q      <= 1'b0;
      start_cnt_q <= '0;
      ready_q     <= 1'b0;
      bcnt_q      <= '0;
      sel_q       <= '0;
      bit_q       <= '0;
      bclk_q      <= 1'b0;
      lrclk_q     <= 1'b0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      fs_q        <= 1'b0;
      running_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mclk_cnt_q  <= mclk_cnt_d;
      mclk_q      <= mclk_d;
      start_cnt_q <= start_cnt_d;
      ready_q     <= ready_d;
      bcnt_q      <= bcnt_d;
      sel_q       <= sel_d;
      bit_q       <= bit_d;
      bclk_q      <= bclk_d;
      lrclk_q     <= lrclk_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      fs_q        <= fs_d;
      running_q   <= running_d;
    end
  end

  assign mclk        = mclk_q;
  assign bclk        = bclk_q;
  assign lrclk       = lrclk_q;
  assign bclk_rise   = rise_q;
  assign bclk_fall   = fall_q;
  assign frame_start = fs_q;
  assign bit_index   = bit_q;
  assign ready       = ready_q;
  assign running     = running_q;

endmodule

// File: tb/tb_audio_clkgen.sv
// Testbench for audio_clkgen: directed and randomized en/sr_sel stimulus,
// every cycle compared against a frame-position reference model.
module tb_audio_clkgen;

  localparam int MCLK_DIV       = 4;
  localparam int BCLK_DIV       = 32;
  localparam int FRAME_BITS     = 32;
  localparam int STARTUP_CYCLES = 512;
  localparam int BIW            = $clog2(FRAME_BITS);

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           en = 1'b0;
  logic [1:0]     sr_sel = 2'd0;
  logic           mclk, bclk, lrclk, bclk_rise, bclk_fall, frame_start;
  logic [BIW-1:0] bit_index;
  logic           ready, running;

  audio_clkgen #(
    .MCLK_DIV      (MCLK_DIV),
    .BCLK_DIV      (BCLK_DIV),
    .FRAME_BITS    (FRAME_BITS),
    .STARTUP_CYCLES(STARTUP_CYCLES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .sr_sel     (sr_sel),
    .mclk       (mclk),
    .bclk       (bclk),
    .lrclk      (lrclk),
    .bclk_rise  (bclk_rise),
    .bclk_fall  (bclk_fall),
    .frame_start(frame_start),
    .bit_index  (bit_index),
    .ready      (ready),
    .running    (running)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: position inside the current frame and its divider.
  int m_n;          // clk edges since reset release
  bit m_active;     // a frame is being generated
  bit m_drain;      // stop at the end of this frame
  bit m_final_fall; // last falling edge when a drained frame ends
  int m_pos;        // clk cycles since the frame started
  int m_div;        // clk cycles per bit in this frame

  int cyc = 0;
  int last_fs_cyc = -1;
  int fs_gap = 0;
  int fs_count = 0;

  task automatic model_reset();
    m_n = 0; m_active = 0; m_drain = 0; m_final_fall = 0; m_pos = 0; m_div = BCLK_DIV;
  endtask

  task automatic model_edge(input bit en_s, input logic [1:0] sel_s);
    bit rdy;
    rdy = (m_n >= STARTUP_CYCLES);
    m_final_fall = 0;
    if (!m_active) begin
      if (rdy && en_s) begin
        m_active = 1; m_drain = 0; m_pos = 0; m_div = BCLK_DIV << sel_s;
      end
    end else if (m_pos == m_div * FRAME_BITS - 1) begin
      if (!m_drain || en_s) begin
        m_pos = 0; m_div = BCLK_DIV << sel_s; m_drain = !en_s;
      end else begin
        m_active = 0; m_final_fall = 1; m_pos = 0;
      end
    end else begin
      m_pos++;
      m_drain = !en_s;
    end
    m_n++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_outputs();
    int ph;
    int bi;
    ph = m_pos % m_div;
    bi = m_pos / m_div;
    chk("mclk",        32'(mclk),        32'((m_n % MCLK_DIV) >= MCLK_DIV / 2));
    chk("ready",       32'(ready),       32'(m_n >= STARTUP_CYCLES));
    chk("running",     32'(running),     32'(m_active));
    chk("bclk",        32'(bclk),        32'(m_active && ph >= m_div / 2));
    chk("bclk_rise",   32'(bclk_rise),   32'(m_active && ph == m_div / 2));
    chk("bclk_fall",   32'(bclk_fall),   32'((m_active && ph == 0) || m_final_fall));
    chk("frame_start", 32'(frame_start), 32'(m_active && m_pos == 0));
    chk("bit_index",   32'(bit_index),   m_active ? 32'(bi) : 32'd0);
    chk("lrclk",       32'(lrclk),       32'(m_active && bi >= FRAME_BITS / 2));
  endtask

  // One clock edge: advance the model with the inputs seen at the edge, then compare.
  task automatic step();
    @(posedge clk);
    model_edge(en, sr_sel);
    cyc++;
    #1;
    check_outputs();
    if (frame_start === 1'b1) begin
      if (last_fs_cyc >= 0) fs_gap = cyc - last_fs_cyc;
      last_fs_cyc = cyc;
      fs_count++;
      $display("frame %0d: cyc=%0d gap=%0d en=%0b sr_sel=%0d", fs_count, cyc, fs_gap, en, sr_sel);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_fs(input int budget);
    int c0;
    int k;
    c0 = fs_count;
    k = 0;
    while (fs_count == c0 && k < budget) begin
      step();
      k++;
    end
    chk("frame_start_seen", 32'(fs_count - c0), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (running === 1'b1 && k < budget) begin
      step();
      k++;
    end
    chk("reached_idle", 32'(running), 32'd0);
  endtask

  initial begin
    int mark;
    int cnt_before;
    model_reset();
    rst_n = 1'b0; en = 1'b1; sr_sel = 2'd0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Startup delay, then T0 one cycle after ready
    run(STARTUP_CYCLES - 1);
    chk("ready_low_511", 32'(ready), 32'd0);
    step();
    chk("ready_at_512", 32'(ready), 32'd1);
    chk("running_lags_ready", 32'(running), 32'd0);
    step();
    chk("t0_frame_start", 32'(frame_start), 32'd1);
    chk("t0_running", 32'(running), 32'd1);
    run(2 * 1024);
    chk("gap_sr0", 32'(fs_gap), 32'd1024);

    // sr_sel change mid-frame takes effect only at the next frame
    run($urandom_range(50, 900));
    sr_sel = 2'd1;
    wait_fs(9000);
    chk("gap_before_sr1", 32'(fs_gap), 32'd1024);
    sr_sel = 2'd3;
    wait_fs(9000);
    chk("gap_sr1", 32'(fs_gap), 32'd2048);
    sr_sel = 2'd0;
    wait_fs(9000);
    chk("gap_sr3", 32'(fs_gap), 32'd8192);
    wait_fs(9000);
    chk("gap_back_sr0", 32'(fs_gap), 32'd1024);

    // en dropped at bit 5: frame completes, then idle
    run(5 * BCLK_DIV + $urandom_range(0, BCLK_DIV - 1));
    chk("at_bit5", 32'(bit_index), 32'd5);
    en = 1'b0;
    mark = last_fs_cyc;
    wait_idle(3000);
    chk("drain_len", 32'(cyc - mark), 32'd1024);
    chk("drain_final_fall", 32'(bclk_fall), 32'd1);
    cnt_before = fs_count;
    run(300);
    chk("no_fs_idle", 32'(fs_count), 32'(cnt_before));
    en = 1'b1;
    step();
    chk("restart_t0", 32'(frame_start), 32'd1);

    // en toggled within one frame: no gap
    run($urandom_range(100, 300));
    en = 1'b0;
    run($urandom_range(50, 300));
    en = 1'b1;
    wait_fs(3000);
    chk("toggle_gap1", 32'(fs_gap), 32'd1024);
    wait_fs(3000);
    chk("toggle_gap2", 32'(fs_gap), 32'd1024);

    // en falls exactly on the frame wrap: new frame starts and is drained
    run(1023);
    en = 1'b0;
    step();
    chk("wrap_en0_fs", 32'(frame_start), 32'd1);
    mark = cyc;
    wait_idle(3000);
    chk("wrap_drain_len", 32'(cyc - mark), 32'd1024);
    en = 1'b1;
    step();

    // Randomized en / sr_sel activity
    for (int s = 0; s < 16; s++) begin
      en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) sr_sel = 2'($urandom_range(0, 1));
      run($urandom_range(40, 1200));
    end
    en = 1'b1;
    sr_sel = 2'd0;

    // Asynchronous reset at T0+300
    wait_fs(9000);
    run(300);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    last_fs_cyc = -1;
    check_outputs();
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_bclk", 32'(bclk), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run(STARTUP_CYCLES - 1);
    chk("ready_low_after_rst", 32'(ready), 32'd0);
    step();
    chk("ready_after_rst", 32'(ready), 32'd1);
    step();
    chk("t0_after_rst", 32'(frame_start), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
